debugger_tx: RTL and testbench
==============================

DEBUGGER_TX -- requirements
Module: debugger_tx

Interface
REQ-001 The module SHALL have parameter DATA_SZ, default 32, giving the PC, register and memory word width in bits (fixed multiple of 8).
REQ-002 The module SHALL have parameter REG_ADDR, default 5, giving the register-file address width; the dump covers 2**REG_ADDR registers.
REQ-003 The module SHALL have parameter MEM_ADDR, default 5, giving the data-memory word address width; the dump covers 2**MEM_ADDR words.
REQ-004 The module SHALL have port i_clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port i_reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port i_send, input, 1 bit, a dump request sampled only in IDLE.
REQ-007 The module SHALL have port i_tx_full, input, 1 bit, the UART TX FIFO full flag.
REQ-008 The module SHALL have port i_pc, input, DATA_SZ bits, the current program counter.
REQ-009 The module SHALL have port i_register_data, input, DATA_SZ bits, combinational register-file read data for o_reg_addr.
REQ-010 The module SHALL have port i_memory_data, input, DATA_SZ bits, combinational data-memory read data for o_mem_addr.
REQ-011 The module SHALL have port o_wr_uart, output, 1 bit, the TX FIFO write strobe.
REQ-012 The module SHALL have port o_w_data, output, 8 bits, the TX FIFO write byte.
REQ-013 The module SHALL have port o_reg_addr, output, REG_ADDR bits, the register-file read address.
REQ-014 The module SHALL have port o_mem_addr, output, MEM_ADDR bits, the data-memory read address.
REQ-015 The module SHALL have port o_busy, output, 1 bit, high from the first cycle after acceptance until the return to IDLE.
REQ-016 The module SHALL have port o_done, output, 1 bit, a one-cycle pulse when the last byte is written.

Function
REQ-017 The FSM SHALL have states IDLE, HDR, LOAD_PC, LOAD_REG, LOAD_MEM, BYTES, CKSUM and DONE.
REQ-018 In IDLE, i_send=1 SHALL move the FSM to HDR on the next edge; i_send is ignored in every other state.
REQ-019 The frame SHALL be sent in this order: header 0xFD, then PC, then registers 0..2**REG_ADDR-1, then memory words 0..2**MEM_ADDR-1, then an optional checksum byte (REQ-031).
REQ-020 Each LOAD_* state SHALL present its address and capture the DATA_SZ-bit input into the shift register at the end of that same cycle, taking exactly one cycle.
REQ-021 BYTES SHALL emit DATA_SZ/8 bytes, least-significant byte first, and then return to the next LOAD_* state or advance past the last word.
REQ-022 A byte SHALL be issued only on an edge where i_tx_full=0 and o_wr_uart=0; o_wr_uart is then registered high for exactly one cycle with o_w_data valid in the same cycle.
REQ-023 Consecutive writes SHALL be separated by at least one idle cycle, and when i_tx_full=1 the FSM SHALL hold state, the shift register and the byte counter indefinitely.
REQ-024 The register and memory address counters SHALL wrap to 0 after the last word, and the wrap SHALL terminate that section.
REQ-025 o_reg_addr and o_mem_addr SHALL remain stable throughout BYTES for the current word.
REQ-026 In DONE, o_done SHALL be high for one cycle, o_busy SHALL be low on the following cycle, and the FSM SHALL return to IDLE.
REQ-027 With defaults, the frame SHALL be 261 bytes without the checksum feature and 262 bytes with it.

Reset
REQ-028 i_reset=0 SHALL immediately force the FSM to IDLE, independent of the clock.
REQ-029 While i_reset=0, the module SHALL hold o_wr_uart=0, o_w_data=0x00, o_reg_addr=0, o_mem_addr=0, o_busy=0 and o_done=0.
REQ-030 A reset asserted mid-frame SHALL abandon the frame, a partial frame SHALL NOT be resumed, and a new i_send SHALL be required after reset.

Configuration
REQ-031 When macro DEBUGGER_TX_CHECKSUM_EN is defined, CKSUM SHALL send one byte equal to the XOR of all preceding frame bytes, header included; when it is undefined, CKSUM and its logic SHALL be absent and the last memory byte SHALL lead directly to DONE.

Verification
REQ-032 Reset release with i_send=1 pulsed, i_tx_full=0, PC=0x00000003 -> first bytes FD 03 00 00 00, and o_wr_uart pulses are never adjacent.
REQ-033 Register model with reg[n]=n and memory model with mem[n]=0x100+n -> reg 31 is sent as 1F 00 00 00 and memory word 0 as 00 01 00 00; the totals are 261 bytes (or 262 bytes with the checksum) and o_done pulses once.
REQ-034 i_tx_full held at 1 for 50 cycles mid-register section -> no writes during those cycles, and the resumed byte stream is identical to the stream with no stalls.
REQ-035 i_send pulsed while o_busy=1 -> ignored, and exactly one frame is sent.
REQ-036 i_reset driven low after byte 100 -> o_wr_uart and o_busy drop without a clock edge; after the next i_send a complete frame is sent starting with 0xFD.
REQ-037 With DEBUGGER_TX_CHECKSUM_EN defined, PC=0 and all registers and memory at 0 -> the final byte is 0xFD.

Source files
------------

// File: rtl/debugger_tx.sv
// debugger_tx: serialises a debug snapshot into the UART TX FIFO.
// Frame: 0xFD header, PC, every register word, every data-memory word,
// each word least-significant byte first.
// Optional feature: define DEBUGGER_TX_CHECKSUM_EN to append one byte
// holding the XOR of every preceding frame byte (header included).
module debugger_tx #(
  parameter int DATA_SZ  = 32,
  parameter int REG_ADDR = 5,
  parameter int MEM_ADDR = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_send,
  input  logic                i_tx_full,
  input  logic [DATA_SZ-1:0]  i_pc,
  input  logic [DATA_SZ-1:0]  i_register_data,
  input  logic [DATA_SZ-1:0]  i_memory_data,
  output logic                o_wr_uart,
  output logic [7:0]          o_w_data,
  output logic [REG_ADDR-1:0] o_reg_addr,
  output logic [MEM_ADDR-1:0] o_mem_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NBYTES = DATA_SZ / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [7:0] HEADER = 8'hFD;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD_PC,
    LOAD_REG,
    LOAD_MEM,
    BYTES,
`ifdef DEBUGGER_TX_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } section_t;

  state_t              state_q;
  state_t              state_d;
  section_t            section_q;
  logic [DATA_SZ-1:0]  shift_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [REG_ADDR-1:0] reg_addr_q;
  logic [MEM_ADDR-1:0] mem_addr_q;
  logic                wr_q;
  logic [7:0]          data_q;
  logic                issue;
  logic [7:0]          tx_byte;
  logic                can_write;
  logic                last_byte;
  logic                reg_last;
  logic                mem_last;
`ifdef DEBUGGER_TX_CHECKSUM_EN
  logic [7:0]          cksum_q;
`endif

  // A byte may only go out when the FIFO has room and no strobe is in
  // flight, which also guarantees an idle cycle between writes.
  assign can_write = !i_tx_full && !wr_q;
  assign last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));
  assign reg_last  = &reg_addr_q;
  assign mem_last  = &mem_addr_q;

  // State register; reset abandons any frame in progress.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the byte to issue this cycle, if any.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      IDLE: begin
        if (i_send) state_d = HDR;
      end
      HDR: begin
        if (can_write) begin
          issue   = 1'b1;
          tx_byte = HEADER;
          state_d = LOAD_PC;
        end
      end
      LOAD_PC:  state_d = BYTES;
      LOAD_REG: state_d = BYTES;
      LOAD_MEM: state_d = BYTES;
      BYTES: begin
        if (can_write) begin
          issue   = 1'b1;
          tx_byte = shift_q[7:0];
          if (last_byte) begin
            case (section_q)
              SEC_PC:  state_d = LOAD_REG;
              SEC_REG: state_d = reg_last ? LOAD_MEM : LOAD_REG;
`ifdef DEBUGGER_TX_CHECKSUM_EN
              SEC_MEM: state_d = mem_last ? CKSUM : LOAD_MEM;
`else
              SEC_MEM: state_d = mem_last ? DONE : LOAD_MEM;
`endif
              default: state_d = IDLE;
            endcase
          end
        end
      end
`ifdef DEBUGGER_TX_CHECKSUM_EN
      CKSUM: begin
        if (can_write) begin
          issue   = 1'b1;
          tx_byte = cksum_q;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: word capture, byte shifting, address walking and the
  // registered FIFO write strobe. Addresses advance only on the edge that
  // sends a word's last byte so they stay stable while it is shifted out.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      section_q  <= SEC_PC;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      wr_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      wr_q <= issue;
      if (issue) data_q <= tx_byte;
      case (state_q)
        IDLE: begin
          if (i_send) begin
            reg_addr_q <= '0;
            mem_addr_q <= '0;
          end
        end
        LOAD_PC: begin
          shift_q    <= i_pc;
          byte_cnt_q <= '0;
          section_q  <= SEC_PC;
        end
        LOAD_REG: begin
          shift_q    <= i_register_data;
          byte_cnt_q <= '0;
          section_q  <= SEC_REG;
        end
        LOAD_MEM: begin
          shift_q    <= i_memory_data;
          byte_cnt_q <= '0;
          section_q  <= SEC_MEM;
        end
        BYTES: begin
          if (can_write) begin
            shift_q    <= shift_q >> 8;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (last_byte) begin
              if (section_q == SEC_REG) reg_addr_q <= reg_addr_q + 1'b1;
              if (section_q == SEC_MEM) mem_addr_q <= mem_addr_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DEBUGGER_TX_CHECKSUM_EN
  // Running XOR of every byte written since the request was accepted.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cksum_q <= 8'h00;
    end else if (state_q == IDLE && i_send) begin
      cksum_q <= 8'h00;
    end else if (issue) begin
      cksum_q <= cksum_q ^ tx_byte;
    end
  end
`endif

  assign o_wr_uart  = wr_q;
  assign o_w_data   = data_q;
  assign o_reg_addr = reg_addr_q;
  assign o_mem_addr = mem_addr_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_debugger_tx.sv
// tb_debugger_tx: scoreboard bench for debugger_tx with default parameters.
// Expected frames are built from a register model reg[n]=n and a memory
// model mem[n]=0x100+n (or all zeros), then compared byte by byte.
module tb_debugger_tx;

`ifdef DEBUGGER_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 262;
`else
  localparam int FRAME_LEN = 261;
`endif

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_send;
  logic        i_tx_full;
  logic [31:0] i_pc;
  logic [31:0] i_register_data;
  logic [31:0] i_memory_data;
  logic        o_wr_uart;
  logic [7:0]  o_w_data;
  logic [4:0]  o_reg_addr;
  logic [4:0]  o_mem_addr;
  logic        o_busy;
  logic        o_done;

  int          total = 0;
  int          bad = 0;
  int          total_bytes = 0;
  int          done_cnt = 0;
  int          stall_writes = 0;
  int          extra_bytes = 0;
  int          byte_base = 0;
  int          done_base = 0;
  bit          zero_mode = 1'b0;
  logic        prev_wr = 1'b0;
  logic [7:0]  last_seen = 8'h00;
  logic [7:0]  exp_last = 8'h00;
  logic [7:0]  model_ck = 8'h00;
  logic [7:0]  exp_q[$];

  debugger_tx dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_send          (i_send),
    .i_tx_full       (i_tx_full),
    .i_pc            (i_pc),
    .i_register_data (i_register_data),
    .i_memory_data   (i_memory_data),
    .o_wr_uart       (o_wr_uart),
    .o_w_data        (o_w_data),
    .o_reg_addr      (o_reg_addr),
    .o_mem_addr      (o_mem_addr),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  assign i_register_data = zero_mode ? 32'h0 : 32'(o_reg_addr);
  assign i_memory_data   = zero_mode ? 32'h0 : 32'h100 + 32'(o_mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    exp_q.push_back(b);
    model_ck = model_ck ^ b;
    exp_last = b;
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) pushByte(w[8*b +: 8]);
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input bit zeros);
    zero_mode = zeros;
    i_pc      = pc;
    model_ck  = 8'h00;
    pushByte(8'hFD);
    pushWord(pc);
    for (int n = 0; n < 32; n++) pushWord(zeros ? 32'h0 : 32'(n));
    for (int n = 0; n < 32; n++) pushWord(zeros ? 32'h0 : 32'h100 + 32'(n));
`ifdef DEBUGGER_TX_CHECKSUM_EN
    pushByte(model_ck);
`endif
    byte_base = total_bytes;
    done_base = done_cnt;
    @(negedge clk);
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic waitDone();
    int i;
    i = 0;
    while (i < 5000) begin
      @(posedge clk);
      #2;
      if (o_done) break;
      i++;
    end
    checkOutput("done_seen", 32'(o_done), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("busy_after_done", 32'(o_busy), 32'd0);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("frame_len", 32'(total_bytes - byte_base), 32'(FRAME_LEN));
    checkOutput("done_pulses", 32'(done_cnt - done_base), 32'd1);
    checkOutput("queue_left", 32'(exp_q.size()), 32'd0);
    checkOutput("extra_bytes", 32'(extra_bytes), 32'd0);
    checkOutput("last_byte", 32'(last_seen), 32'(exp_last));
  endtask

  task automatic waitBytes(input int n);
    int i;
    i = 0;
    while ((total_bytes - byte_base) < n && i < 5000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("reach_bytes", 32'((total_bytes - byte_base) >= n), 32'd1);
  endtask

  // Monitor: sample outputs 1 time unit after each rising edge and pop
  // the scoreboard on every write strobe.
  always @(posedge clk) begin
    logic full_at_edge;
    logic [7:0] e;
    full_at_edge = i_tx_full;
    #1;
    if (i_reset) begin
      if (o_wr_uart) begin
        checkOutput("gap", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          extra_bytes++;
        end else begin
          e = exp_q.pop_front();
          checkOutput("byte", 32'(o_w_data), 32'(e));
        end
        total_bytes++;
        if (full_at_edge) stall_writes++;
        last_seen = o_w_data;
      end
      if (o_done) done_cnt++;
      prev_wr = o_wr_uart;
    end else begin
      prev_wr = 1'b0;
    end
  end

  initial begin
    int sb;
    int bb;
    int i;
    i_reset   = 1'b0;
    i_send    = 1'b0;
    i_tx_full = 1'b0;
    i_pc      = 32'h0;
    #12;
    checkOutput("rst_wr", 32'(o_wr_uart), 32'd0);
    checkOutput("rst_data", 32'(o_w_data), 32'd0);
    checkOutput("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    checkOutput("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    i_reset = 1'b1;

    // Plain frame, PC = 3.
    applyStimulus(32'h0000_0003, 1'b0);
    waitDone();

    // Back-pressure mid register section plus a send while busy.
    applyStimulus(32'hA5C3_1E07, 1'b0);
    waitBytes(20);
    i_tx_full = 1'b1;
    sb = stall_writes;
    bb = total_bytes;
    repeat (10) @(negedge clk);
    checkOutput("busy_mid", 32'(o_busy), 32'd1);
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    repeat (39) @(negedge clk);
    checkOutput("stall_writes", 32'(stall_writes - sb), 32'd0);
    checkOutput("stall_hold", 32'(total_bytes - bb), 32'd0);
    i_tx_full = 1'b0;
    waitDone();

    // Asynchronous reset mid-frame, then a fresh frame.
    applyStimulus(32'h1234_5678, 1'b0);
    waitBytes(100);
    i = 0;
    while (i < 20) begin
      @(posedge clk);
      #2;
      if (o_wr_uart) break;
      i++;
    end
    checkOutput("pre_rst_wr", 32'(o_wr_uart), 32'd1);
    #1;
    i_reset = 1'b0;
    #1;
    checkOutput("async_wr", 32'(o_wr_uart), 32'd0);
    checkOutput("async_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    checkOutput("rst2_data", 32'(o_w_data), 32'd0);
    checkOutput("rst2_reg_addr", 32'(o_reg_addr), 32'd0);
    checkOutput("rst2_mem_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("rst2_done", 32'(o_done), 32'd0);
    i_reset = 1'b1;
    bb = total_bytes;
    repeat (10) @(negedge clk);
    checkOutput("no_resume_busy", 32'(o_busy), 32'd0);
    checkOutput("no_resume_bytes", 32'(total_bytes - bb), 32'd0);
    applyStimulus(32'hFFFF_0001, 1'b0);
    waitDone();

    // All-zero snapshot: checksum, if enabled, must equal the header.
    applyStimulus(32'h0000_0000, 1'b1);
    waitDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
